// File: rtl/keynsham_vic.sv
// keynsham_vic: vectored IRQ controller on the 30-bit word-addressed Keynsham bus, single registered irq_req.
// Build option KEYNSHAM_VIC_PRIORITY_EN adds the ACTIVE priority encoder at address 6 (reads 0 otherwise).
module keynsham_vic #(
   parameter int nr_irqs     = 4,
   parameter int sync_stages = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bus_access,
   input  logic               bus_cs,
   input  logic [29:0]        bus_addr,
   input  logic [31:0]        bus_wr_val,
   input  logic               bus_wr_en,
   input  logic [3:0]         bus_bytesel,
   output logic               bus_error,
   output logic               bus_ack,
   output logic [31:0]        bus_data,
   input  logic [nr_irqs-1:0] irq_in,
   output logic               irq_req
);

   logic [sync_stages-1:0][nr_irqs-1:0] chain;
   logic [nr_irqs-1:0] sync, sync_d, enable, test, mode, pending;
   logic [nr_irqs-1:0] enable_n, test_n, mode_n, pending_n;
   logic [nr_irqs-1:0] edge_set, src, status, wbits, keep;
   logic [31:0]        wmask, wfull, status32, active, rdata;
   logic [2:0]         addr;
   logic               ctrl_access, do_wr, ro_addr;
   logic               unused_ok;

   assign ctrl_access = bus_access & bus_cs;
   assign addr        = bus_addr[2:0];
   assign wmask       = {{8{bus_bytesel[3]}}, {8{bus_bytesel[2]}},
                         {8{bus_bytesel[1]}}, {8{bus_bytesel[0]}}};
   assign wfull       = bus_wr_val & wmask;
   assign wbits       = wfull[nr_irqs-1:0];
   assign keep        = ~wmask[nr_irqs-1:0];
   assign ro_addr     = (addr == 3'd0) || (addr == 3'd6) || (addr == 3'd7);
   assign do_wr       = ctrl_access & bus_wr_en & ~ro_addr;
   assign unused_ok   = &{1'b0, bus_addr[29:3], wfull, wmask};

   assign sync     = chain[sync_stages-1];
   assign src      = (mode & pending) | (~mode & sync);
   assign status   = (src | test) & enable;
   assign status32 = 32'(status);
   assign edge_set = sync & ~sync_d & mode;

   always_comb begin
      enable_n  = enable;
      test_n    = test;
      mode_n    = mode;
      pending_n = pending;
      if (do_wr) begin
         case (addr)
            3'd1:    enable_n  = enable | wbits;
            3'd2:    enable_n  = enable & ~wbits;
            3'd3:    test_n    = (test & keep) | wbits;
            3'd4:    mode_n    = (mode & keep) | wbits;
            3'd5:    pending_n = pending & ~wbits;
            default: ;
         endcase
      end
      // A fresh edge beats a same-cycle CLEAR; leaving edge mode drops the bit.
      pending_n = (pending_n | edge_set) & mode_n;
   end

`ifdef KEYNSHAM_VIC_PRIORITY_EN
   logic       act_vld;
   logic [4:0] act_idx;

   always_comb begin
      act_vld = 1'b0;
      act_idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (status32[i]) begin
            act_vld = 1'b1;
            act_idx = 5'(i);
         end
      end
   end

   assign active = {act_vld, 26'd0, act_idx};
`else
   assign active = 32'd0;
`endif

   always_comb begin
      rdata = 32'd0;
      case (addr)
         3'd0:    rdata = status32;
         3'd1:    rdata = 32'(enable);
         3'd3:    rdata = 32'(test);
         3'd4:    rdata = 32'(mode);
         3'd6:    rdata = active;
         3'd7:    rdata = 32'(sync);
         default: rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain     <= '0;
         sync_d    <= '0;
         enable    <= '0;
         test      <= '0;
         mode      <= '0;
         pending   <= '0;
         irq_req   <= 1'b0;
         bus_ack   <= 1'b0;
         bus_error <= 1'b0;
         bus_data  <= 32'd0;
      end else begin
         chain[0] <= irq_in;
         for (int s = 1; s < sync_stages; s++) chain[s] <= chain[s-1];
         sync_d    <= sync;
         enable    <= enable_n;
         test      <= test_n;
         mode      <= mode_n;
         pending   <= pending_n;
         irq_req   <= |status;
         bus_ack   <= ctrl_access;
         bus_error <= ctrl_access & bus_wr_en & ro_addr;
         bus_data  <= (ctrl_access & ~bus_wr_en) ? rdata : 32'd0;
      end
   end

endmodule
